// File: rtl/fb_pixel_writer_if.sv
// Pixel stream handshake into the frame-buffer writer: valid/ready with a
// start-of-frame qualifier on the first pixel of each raster frame.
interface fb_pixel_writer_if #(
    parameter int DATA_W = 24
);
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              pix_sof;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_sof,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_sof,
        output pix_ready
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// Frame-buffer port-A write engine: raster pixel stream to linear address y*H_RES+x.
// Define FB_WRITER_CLEAR_EN to build in the whole-frame colour clear engine.
module fb_pixel_writer #(
    parameter int H_RES  = 300,
    parameter int V_RES  = 300,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    fb_pixel_writer_if.slave     pix,
    input  logic                 clear_req,
    input  logic [DATA_W-1:0]    fill_color,
    output logic                 mem_we_a,
    output logic [ADDR_W-1:0]    mem_addr_a,
    output logic [DATA_W-1:0]    mem_wdata_a,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 sync_err
);

    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;

    localparam logic [X_W-1:0]    X_LAST    = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_RES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        CLEAR
    } state_t;

    state_t            state;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addr;

    logic              take_clear;
    logic              ready_c;
    logic              xfer;
    logic              wr_pix;
    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic [ADDR_W-1:0] cur_addr;
    logic              at_last;

`ifdef FB_WRITER_CLEAR_EN
    logic [DATA_W-1:0] fill_q;

    assign take_clear = (state == IDLE) && clear_req;
`else
    logic unused_clear;

    assign take_clear   = 1'b0;
    assign unused_clear = ^{clear_req, fill_color};
`endif

    always_comb begin
        ready_c = 1'b0;
        if (!rst) begin
            if (state == IDLE)
                ready_c = !take_clear;
            else if (state == STREAM)
                ready_c = 1'b1;
            else
                ready_c = 1'b0;
        end
    end

    assign pix.pix_ready = ready_c;
    assign xfer          = pix.pix_valid && ready_c;

    // A sof pixel always lands at the origin, whether it starts a frame or
    // resynchronises one already in flight.
    assign wr_pix   = xfer && (pix.pix_sof || (state == STREAM));
    assign cur_x    = pix.pix_sof ? '0 : x;
    assign cur_y    = pix.pix_sof ? '0 : y;
    assign cur_addr = pix.pix_sof ? '0 : addr;
    assign at_last  = (cur_x == X_LAST) && (cur_y == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            addr        <= '0;
            mem_we_a    <= 1'b0;
            mem_addr_a  <= '0;
            mem_wdata_a <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
`ifdef FB_WRITER_CLEAR_EN
            fill_q      <= '0;
`endif
        end else begin
            mem_we_a   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= (state != IDLE);
            sync_err   <= xfer && ((state == IDLE) ? !pix.pix_sof : pix.pix_sof);

            if (wr_pix) begin
                mem_we_a    <= 1'b1;
                mem_addr_a  <= cur_addr;
                mem_wdata_a <= pix.pix_data;
                if (at_last) begin
                    frame_done <= 1'b1;
                    state      <= IDLE;
                    x          <= '0;
                    y          <= '0;
                    addr       <= '0;
                end else begin
                    state <= STREAM;
                    addr  <= cur_addr + 1'b1;
                    if (cur_x == X_LAST) begin
                        x <= '0;
                        y <= cur_y + 1'b1;
                    end else begin
                        x <= cur_x + 1'b1;
                        y <= cur_y;
                    end
                end
            end

`ifdef FB_WRITER_CLEAR_EN
            // Address 0 is written on the accept edge so a clear occupies
            // exactly H_RES*V_RES write cycles.
            if (take_clear) begin
                fill_q      <= fill_color;
                mem_we_a    <= 1'b1;
                mem_addr_a  <= '0;
                mem_wdata_a <= fill_color;
                if (LAST_ADDR == '0) begin
                    frame_done <= 1'b1;
                end else begin
                    state <= CLEAR;
                    addr  <= ADDR_W'(1);
                end
            end else if (state == CLEAR) begin
                mem_we_a    <= 1'b1;
                mem_addr_a  <= addr;
                mem_wdata_a <= fill_q;
                if (addr == LAST_ADDR) begin
                    frame_done <= 1'b1;
                    state      <= IDLE;
                    addr       <= '0;
                end else begin
                    addr <= addr + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: a 4x3 instance for the functional
// scenarios and a default 300x300 instance for the full-size frame.
module tb_fb_pixel_writer;

    localparam int AW = 17;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4x3 instance
    fb_pixel_writer_if #(.DATA_W(DW)) s_if ();
    logic          s_clear_req;
    logic [DW-1:0] s_fill;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_busy, s_fd, s_se;

    fb_pixel_writer #(.H_RES(4), .V_RES(3), .ADDR_W(AW), .DATA_W(DW)) dut_s (
        .clk         (clk),
        .rst         (rst),
        .pix         (s_if.slave),
        .clear_req   (s_clear_req),
        .fill_color  (s_fill),
        .mem_we_a    (s_we),
        .mem_addr_a  (s_addr),
        .mem_wdata_a (s_wdata),
        .busy        (s_busy),
        .frame_done  (s_fd),
        .sync_err    (s_se)
    );

    // 300x300 default instance
    fb_pixel_writer_if #(.DATA_W(DW)) b_if ();
    logic          b_clear_req;
    logic [DW-1:0] b_fill;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_busy, b_fd, b_se;

    fb_pixel_writer dut_b (
        .clk         (clk),
        .rst         (rst),
        .pix         (b_if.slave),
        .clear_req   (b_clear_req),
        .fill_color  (b_fill),
        .mem_we_a    (b_we),
        .mem_addr_a  (b_addr),
        .mem_wdata_a (b_wdata),
        .busy        (b_busy),
        .frame_done  (b_fd),
        .sync_err    (b_se)
    );

    task automatic drive(input logic v, input logic sof, input logic [DW-1:0] d);
        s_if.pix_valid = v;
        s_if.pix_sof   = sof;
        s_if.pix_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_if.pix_valid = 1'b1;
        s_if.pix_sof   = 1'b1;
        s_if.pix_data  = 24'hDEAD00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (s_if.pix_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", s_if.pix_ready);
        end
        checks++;
        if (s_we !== 1'b0 || s_addr !== '0 || s_wdata !== '0) begin
            errors++; $display("FAIL reset_mem: we=%b addr=%0d data=%h want 0/0/0", s_we, s_addr, s_wdata);
        end
        checks++;
        if (s_busy !== 1'b0 || s_fd !== 1'b0 || s_se !== 1'b0) begin
            errors++; $display("FAIL reset_flags: busy=%b fd=%b se=%b want 000", s_busy, s_fd, s_se);
        end
        s_if.pix_valid = 1'b0;
        s_if.pix_sof   = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (s_if.pix_ready !== 1'b1) begin
            errors++; $display("FAIL idle_ready: got %b want 1", s_if.pix_ready);
        end
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < 12; i++) begin
            s_if.pix_valid = 1'b1;
            s_if.pix_sof   = (i == 0);
            s_if.pix_data  = DW'(i);
            #1;
            checks++;
            if (s_if.pix_ready !== 1'b1) begin
                errors++; $display("FAIL frame_ready[%0d]: got %b want 1", i, s_if.pix_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (s_we !== 1'b1 || s_addr !== AW'(i) || s_wdata !== DW'(i)) begin
                errors++; $display("FAIL frame_wr[%0d]: we=%b addr=%0d data=%h want 1/%0d/%h", i, s_we, s_addr, s_wdata, i, i);
            end
            checks++;
            if (s_fd !== (i == 11) || s_se !== 1'b0 || s_busy !== (i >= 1)) begin
                errors++; $display("FAIL frame_flags[%0d]: fd=%b se=%b busy=%b", i, s_fd, s_se, s_busy);
            end
        end
        drive(1'b0, 1'b0, 24'h0);
        checks++;
        if (s_we !== 1'b0 || s_addr !== AW'(11) || s_busy !== 1'b0 || s_fd !== 1'b0) begin
            errors++; $display("FAIL frame_end: we=%b addr=%0d busy=%b fd=%b want 0/11/0/0", s_we, s_addr, s_busy, s_fd);
        end
    endtask

    task automatic test_stalls();
        logic [15:0] pat;
        logic        v;
        int          k;
        int          cyc;
        pat = 16'b1001_1101_0110_0101;
        k   = 0;
        cyc = 0;
        while (k < 12 && cyc < 100) begin
            v = pat[cyc % 16];
            drive(v, v && (k == 0), DW'(24'h100 + k));
            checks++;
            if (v) begin
                if (s_we !== 1'b1 || s_addr !== AW'(k) || s_wdata !== DW'(24'h100 + k) || s_fd !== (k == 11)) begin
                    errors++; $display("FAIL stall_wr[%0d]: we=%b addr=%0d data=%h fd=%b", k, s_we, s_addr, s_wdata, s_fd);
                end
                k++;
            end else if (s_we !== 1'b0 || s_fd !== 1'b0) begin
                errors++; $display("FAIL stall_idle[cyc %0d]: we=%b fd=%b want 0/0", cyc, s_we, s_fd);
            end
            cyc++;
        end
        s_if.pix_valid = 1'b0;
        checks++;
        if (k != 12) begin
            errors++; $display("FAIL stall_timeout: %0d pixels written want 12", k);
        end
    endtask

    task automatic test_sync_err();
        drive(1'b1, 1'b0, 24'h123456);
        checks++;
        if (s_we !== 1'b0 || s_se !== 1'b1 || s_addr !== AW'(11)) begin
            errors++; $display("FAIL sync_idle: we=%b se=%b addr=%0d want 0/1/11", s_we, s_se, s_addr);
        end
        drive(1'b0, 1'b0, 24'h0);
        checks++;
        if (s_se !== 1'b0) begin
            errors++; $display("FAIL sync_pulse: se=%b want 0", s_se);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i == 0), DW'(24'h10 + i));
            checks++;
            if (s_we !== 1'b1 || s_addr !== AW'(i) || s_se !== 1'b0) begin
                errors++; $display("FAIL sync_pre[%0d]: we=%b addr=%0d se=%b", i, s_we, s_addr, s_se);
            end
        end
        drive(1'b1, 1'b1, 24'hABCDEF);
        checks++;
        if (s_we !== 1'b1 || s_addr !== AW'(0) || s_wdata !== 24'hABCDEF || s_se !== 1'b1) begin
            errors++; $display("FAIL sync_mid: we=%b addr=%0d data=%h se=%b want 1/0/abcdef/1", s_we, s_addr, s_wdata, s_se);
        end
        drive(1'b1, 1'b0, 24'h777777);
        checks++;
        if (s_we !== 1'b1 || s_addr !== AW'(1) || s_wdata !== 24'h777777 || s_se !== 1'b0) begin
            errors++; $display("FAIL sync_next: we=%b addr=%0d data=%h se=%b want 1/1/777777/0", s_we, s_addr, s_wdata, s_se);
        end
        for (int i = 2; i < 12; i++) drive(1'b1, 1'b0, DW'(i));
        checks++;
        if (s_addr !== AW'(11) || s_fd !== 1'b1) begin
            errors++; $display("FAIL sync_finish: addr=%0d fd=%b want 11/1", s_addr, s_fd);
        end
        drive(1'b0, 1'b0, 24'h0);
    endtask

`ifdef FB_WRITER_CLEAR_EN
    task automatic test_clear();
        s_clear_req    = 1'b1;
        s_fill         = 24'hFF0000;
        s_if.pix_valid = 1'b1;
        s_if.pix_sof   = 1'b1;
        s_if.pix_data  = 24'h55AA55;
        #1;
        checks++;
        if (s_if.pix_ready !== 1'b0) begin
            errors++; $display("FAIL clear_ready: got %b want 0", s_if.pix_ready);
        end
        @(posedge clk); #1;
        s_clear_req = 1'b0;
        s_fill      = 24'h0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            checks++;
            if (s_we !== 1'b1 || s_addr !== AW'(k) || s_wdata !== 24'hFF0000 || s_fd !== (k == 11)) begin
                errors++; $display("FAIL clear_wr[%0d]: we=%b addr=%0d data=%h fd=%b", k, s_we, s_addr, s_wdata, s_fd);
            end
            checks++;
            if (s_busy !== (k >= 1) || s_if.pix_ready !== (k == 11)) begin
                errors++; $display("FAIL clear_state[%0d]: busy=%b ready=%b", k, s_busy, s_if.pix_ready);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (s_we !== 1'b1 || s_addr !== AW'(0) || s_wdata !== 24'h55AA55 || s_se !== 1'b0 || s_busy !== 1'b0) begin
            errors++; $display("FAIL clear_held_sof: we=%b addr=%0d data=%h se=%b busy=%b", s_we, s_addr, s_wdata, s_se, s_busy);
        end
        s_if.pix_valid = 1'b0;
        s_if.pix_sof   = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask
`else
    task automatic test_clear_ignored();
        s_clear_req    = 1'b1;
        s_fill         = 24'hFF0000;
        s_if.pix_valid = 1'b1;
        s_if.pix_sof   = 1'b1;
        s_if.pix_data  = 24'h55AA55;
        #1;
        checks++;
        if (s_if.pix_ready !== 1'b1) begin
            errors++; $display("FAIL noclear_ready: got %b want 1", s_if.pix_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (s_we !== 1'b1 || s_addr !== AW'(0) || s_wdata !== 24'h55AA55) begin
            errors++; $display("FAIL noclear_wr: we=%b addr=%0d data=%h want 1/0/55aa55", s_we, s_addr, s_wdata);
        end
        s_clear_req = 1'b0;
        drive(1'b0, 1'b0, 24'h0);
        checks++;
        if (s_we !== 1'b0) begin
            errors++; $display("FAIL noclear_quiet: we=%b want 0", s_we);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 7; i++) drive(1'b1, (i == 0), DW'(24'h200 + i));
        rst = 1'b1;
        s_if.pix_valid = 1'b1;
        s_if.pix_sof   = 1'b0;
        s_if.pix_data  = 24'h999999;
        #1;
        checks++;
        if (s_if.pix_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_ready: got %b want 0", s_if.pix_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (s_we !== 1'b0 || s_addr !== '0 || s_wdata !== '0 || s_busy !== 1'b0 || s_fd !== 1'b0 || s_se !== 1'b0) begin
            errors++; $display("FAIL rstmid_out: we=%b addr=%0d data=%h busy=%b fd=%b se=%b", s_we, s_addr, s_wdata, s_busy, s_fd, s_se);
        end
        drive(1'b1, 1'b1, 24'h314159);
        checks++;
        if (s_we !== 1'b1 || s_addr !== AW'(0) || s_wdata !== 24'h314159 || s_se !== 1'b0) begin
            errors++; $display("FAIL rstmid_sof: we=%b addr=%0d data=%h se=%b want 1/0/314159/0", s_we, s_addr, s_wdata, s_se);
        end
        drive(1'b1, 1'b0, 24'h271828);
        checks++;
        if (s_we !== 1'b1 || s_addr !== AW'(1) || s_wdata !== 24'h271828) begin
            errors++; $display("FAIL rstmid_next: we=%b addr=%0d data=%h want 1/1/271828", s_we, s_addr, s_wdata);
        end
        drive(1'b0, 1'b0, 24'h0);
    endtask

    task automatic test_default_size();
        int bad;
        int max_addr;
        int fd_early;
        bad      = 0;
        max_addr = 0;
        fd_early = 0;
        for (int i = 0; i < 90000; i++) begin
            b_if.pix_valid = 1'b1;
            b_if.pix_sof   = (i == 0);
            b_if.pix_data  = DW'(i);
            @(posedge clk); #1;
            if (b_we !== 1'b1 || b_addr !== AW'(i) || b_wdata !== DW'(i)) begin
                if (bad == 0)
                    $display("FAIL big_seq[%0d]: we=%b addr=%0d data=%h want 1/%0d/%h", i, b_we, b_addr, b_wdata, i, i);
                bad++;
            end
            if (int'(b_addr) > max_addr) max_addr = int'(b_addr);
            if (i < 89999 && b_fd !== 1'b0) fd_early++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL big_seq_total: %0d bad writes want 0", bad);
        end
        checks++;
        if (b_addr !== AW'(89999) || b_fd !== 1'b1) begin
            errors++; $display("FAIL big_last: addr=%0d fd=%b want 89999/1", b_addr, b_fd);
        end
        checks++;
        if (fd_early != 0) begin
            errors++; $display("FAIL big_fd_early: %0d early pulses want 0", fd_early);
        end
        b_if.pix_valid = 1'b0;
        b_if.pix_sof   = 1'b0;
        @(posedge clk); #1;
        if (int'(b_addr) > max_addr) max_addr = int'(b_addr);
        checks++;
        if (b_we !== 1'b0 || max_addr != 89999 || b_fd !== 1'b0) begin
            errors++; $display("FAIL big_after: we=%b max_addr=%0d fd=%b want 0/89999/0", b_we, max_addr, b_fd);
        end
    endtask

    initial begin
        s_if.pix_valid = 1'b0;
        s_if.pix_sof   = 1'b0;
        s_if.pix_data  = '0;
        s_clear_req    = 1'b0;
        s_fill         = '0;
        b_if.pix_valid = 1'b0;
        b_if.pix_sof   = 1'b0;
        b_if.pix_data  = '0;
        b_clear_req    = 1'b0;
        b_fill         = '0;

        test_reset();
        test_full_frame();
        test_stalls();
        test_sync_err();
`ifdef FB_WRITER_CLEAR_EN
        test_clear();
`else
        test_clear_ignored();
`endif
        test_reset_mid_frame();
        test_default_size();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Write-side engine for the dual-port frame buffer. Accepts a raster-ordered 24-bit RGB pixel stream with valid/ready handshake and start-of-frame marker, and issues one write per pixel on memory port A at linear address `y*H_RES + x`. The HDMI scan-out path reads the same memory on port B using the same address mapping. Optionally includes a clear engine that floods the whole frame with one colour.

## Interface

**Parameters**
- `H_RES`, default 300: pixels per line.
- `V_RES`, default 300: lines per frame.
- `ADDR_W`, default 17: memory address width; must satisfy `H_RES*V_RES <= 2**ADDR_W`.
- `DATA_W`, default 24: pixel width, RGB 8:8:8.

**Ports**
- `clk` in 1: single clock, same domain as port A (`clk_a`).
- `rst` in 1: synchronous, active-high reset.
- `pix_valid` in 1: the stream pixel is valid.
- `pix_ready` out 1: the block accepts the pixel this cycle.
- `pix_data` in DATA_W: pixel colour.
- `pix_sof` in 1: qualifies the first pixel of a frame, i.e. x=0, y=0.
- `clear_req` in 1: one-cycle request to fill the frame with `fill_color`.
- `fill_color` in DATA_W: clear colour, sampled when `clear_req` is taken.
- `mem_we_a` out 1: port-A write enable.
- `mem_addr_a` out ADDR_W: port-A address.
- `mem_wdata_a` out DATA_W: port-A write data.
- `busy` out 1: high in STREAM or CLEAR.
- `frame_done` out 1: one-cycle pulse when the last address of a frame or clear is written.
- `sync_err` out 1: one-cycle pulse when a pixel is accepted in IDLE without `pix_sof`, or when `pix_sof` arrives mid-frame.

## Operation

**Handshake:** a pixel transfers when `pix_valid && pix_ready`.

**States:** IDLE, STREAM, CLEAR. Reset puts the block in IDLE.

**IDLE**
- `pix_ready` = `!clear_req`.
- An accepted pixel with `pix_sof` is written to address 0, x and y are set to 1 and 0, and the state moves to STREAM.
- An accepted pixel without `pix_sof` is discarded: no write, `sync_err` pulses.
- `clear_req` moves the state to CLEAR and latches `fill_color`. It has priority over a simultaneous pixel; that pixel is not accepted because `pix_ready` is low.

**STREAM**
- `pix_ready` = 1.
- Each accepted pixel is written to the running linear address, which increments by 1. No multiplier is used.
- x wraps from H_RES-1 to 0, and y then increments.
- The pixel at x=H_RES-1, y=V_RES-1 produces its write and `frame_done`, and the state returns to IDLE.
- An accepted pixel with `pix_sof` mid-frame pulses `sync_err`, writes to address 0, and restarts counters at x=1, y=0.
- `clear_req` is ignored in STREAM.

**CLEAR**
- `pix_ready` = 0.
- One write of the latched colour per cycle, addresses 0 through H_RES*V_RES-1.
- The final write pulses `frame_done`; the state then returns to IDLE.

**Arithmetic**
- Address counter is ADDR_W bits; x is sized to clog2(H_RES) bits and y to clog2(V_RES) bits.
- All comparisons are against parameter-derived constants.
- No address ever exceeds H_RES*V_RES-1.

## Timing

- **Reset values:** `pix_ready`=0 during reset. `mem_we_a`=0, `mem_addr_a`=0, `mem_wdata_a`=0, `busy`=0, `frame_done`=0, `sync_err`=0.
- **Write latency:** all memory outputs are registered. A handshake at edge N gives `mem_we_a`=1 with the address and data valid for the cycle after edge N, so 1 cycle. Outside a write, `mem_we_a`=0, and `mem_addr_a`/`mem_wdata_a` hold their last values.
- **Throughput:** one pixel per cycle in STREAM, sustained. Back-to-back frames are allowed: the cycle after the last pixel, IDLE accepts the next `pix_sof`.
- **Pulse alignment:** `frame_done` and `sync_err` are registered and align with the write (or would-be write) cycle of the triggering pixel.
- **CLEAR timing:** the first write occurs the cycle after `clear_req` is taken. A clear takes exactly H_RES*V_RES cycles. `busy` rises the cycle after entry to CLEAR and falls the cycle after the `frame_done` cycle.
- **Reset mid-operation:** `rst` high at any edge aborts STREAM or CLEAR. `mem_we_a` is 0 from the next cycle, counters return to 0, and a partial frame is left in memory unmodified.

## Configuration

- `FB_WRITER_CLEAR_EN` defined: CLEAR state, `fill_color` latch and clear address sequencing are compiled in, as described above.
- `FB_WRITER_CLEAR_EN` undefined: CLEAR logic is absent. `clear_req` and `fill_color` remain as ports but are ignored. In IDLE, `pix_ready` is a constant 1.

## Test plan

Use H_RES=4, V_RES=3 except where noted.

- **Full frame:** stream 12 pixels, `pix_data`=0x000000..0x00000B, `pix_sof` on the first, `pix_valid` constant. Expect writes to addresses 0..11 with matching data, each one cycle after its handshake. `frame_done` pulses with the address-11 write. The state returns to IDLE.
- **Stalls:** repeat the full frame with `pix_valid` toggled pseudo-randomly. Expect identical address/data pairs and no writes on invalid cycles.
- **Sync errors:** in IDLE send 0x123456 without `pix_sof`. Expect no write and a `sync_err` pulse. Then send 5 pixels of a frame followed by `pix_sof` with 0xABCDEF. Expect `sync_err`, a write of 0xABCDEF at address 0, and the next pixel written to address 1.
- **Clear:** with `FB_WRITER_CLEAR_EN` defined, assert `clear_req` with `fill_color`=0xFF0000 while `pix_valid`=1 and `pix_sof`=1. Expect `pix_ready`=0 that cycle and 12 consecutive writes of 0xFF0000 to addresses 0..11. `frame_done` pulses on address 11. The held sof pixel is accepted in IDLE afterwards and written to address 0.
- **Reset mid-frame:** assert `rst` for one cycle after 7 pixels. Expect `mem_we_a`=0 the next cycle and all outputs at reset values. A new sof pixel then writes to address 0.
- **Default size:** H_RES=300, V_RES=300. Stream the full frame and expect the last write at address 89999, with `frame_done` on that write and no address beyond it.
